// File: rtl/stream_arbiter_if.sv
// Source-side and output-side stream signals of the arbiter.
// master: the arbiter itself (drives src_ready and the M_AXIS outputs).
// slave:  the environment (drives the sources and the downstream ready).
interface stream_arbiter_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int NUM_SOURCES = 4,
  parameter int FIFO_DEPTH  = 16
);
  logic [NUM_SOURCES-1:0]            src_valid;
  logic [NUM_SOURCES-1:0]            src_last;
  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data;
  logic [NUM_SOURCES-1:0]            src_ready;
  logic [DATA_WIDTH-1:0]             M_AXIS_tdata;
  logic [2:0]                        M_AXIS_tid;
  logic                              M_AXIS_tlast;
  logic                              M_AXIS_tvalid;
  logic                              M_AXIS_tready;
  logic [$clog2(FIFO_DEPTH):0]       fifo_count;

  modport master (
    input  src_valid, src_last, src_data, M_AXIS_tready,
    output src_ready, M_AXIS_tdata, M_AXIS_tid, M_AXIS_tlast, M_AXIS_tvalid,
           fifo_count
  );

  modport slave (
    output src_valid, src_last, src_data, M_AXIS_tready,
    input  src_ready, M_AXIS_tdata, M_AXIS_tid, M_AXIS_tlast, M_AXIS_tvalid,
           fifo_count
  );
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin packet arbiter: merges NUM_SOURCES packet streams into one
// tagged output stream through a first-word fall-through buffer. A grant is
// locked for a whole packet, so packets never interleave.
module stream_arbiter #(
  parameter int DATA_WIDTH  = 128,
  parameter int NUM_SOURCES = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  stream_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_SOURCES);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef struct packed {
    logic [2:0]            id;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {IDLE, GRANT, PACKET} state_t;

  state_t                                 state, state_nxt;
  logic [IDW-1:0]                         gnt, gnt_nxt, rr_pick;
  logic                                   rr_found;
  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_data_a;
  logic [NUM_SOURCES-1:0]                 rdy;
  beat_t                                  mem [FIFO_DEPTH];
  beat_t                                  head, wr_beat;
  logic [AW-1:0]                          wr_ptr, rd_ptr;
  logic [CW-1:0]                          count;
  logic                                   full, grant_open, push, pop, tvalid;

  assign src_data_a = bus.src_data;
  assign full       = (count == CW'(FIFO_DEPTH));
  // Ready depends only on registered state, never on tready.
  assign grant_open = (state != IDLE) && !full;
  assign push       = grant_open && bus.src_valid[gnt];
  assign tvalid     = (count != '0);
  assign pop        = tvalid && bus.M_AXIS_tready;
  assign wr_beat    = '{id: 3'(gnt), last: bus.src_last[gnt], data: src_data_a[gnt]};
  assign head       = mem[rd_ptr];

  // Round-robin pick: first requester strictly after the previous grant.
  always_comb begin
    rr_pick  = gnt;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      if (!rr_found && bus.src_valid[IDW'((int'(gnt) + k) % NUM_SOURCES)]) begin
        rr_pick  = IDW'((int'(gnt) + k) % NUM_SOURCES);
        rr_found = 1'b1;
      end
    end
  end

  // Next state, next grant and the one-hot ready.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rdy       = '0;
    rdy[gnt]  = grant_open;
    case (state)
      IDLE: begin
        if (rr_found) begin
          gnt_nxt   = rr_pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (push)                       state_nxt = bus.src_last[gnt] ? IDLE : PACKET;
        else if (!bus.src_valid[gnt])   state_nxt = IDLE;  // release unused grant
      end
      PACKET: begin
        if (push && bus.src_last[gnt])  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and grant registers; reset makes source 0 win the first contest.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      gnt   <= IDW'(NUM_SOURCES - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; contents are only visible while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  assign bus.src_ready     = rdy;
  assign bus.M_AXIS_tvalid = tvalid;
  assign bus.M_AXIS_tdata  = tvalid ? head.data : '0;
  assign bus.M_AXIS_tid    = tvalid ? head.id   : '0;
  assign bus.M_AXIS_tlast  = tvalid ? head.last : 1'b0;
  assign bus.fifo_count    = count;
endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: directed scenarios plus randomized traffic,
// checked against an acceptance-order scoreboard and packet-level rules.
module tb_stream_arbiter;
  localparam int DW = 128;
  localparam int NS = 4;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  stream_arbiter_if #(.DATA_WIDTH(DW), .NUM_SOURCES(NS), .FIFO_DEPTH(FD)) bus ();
  stream_arbiter #(.DATA_WIDTH(DW), .NUM_SOURCES(NS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));

  typedef struct packed {
    logic [2:0]    tid;
    logic          last;
    logic [DW-1:0] data;
  } ob_t;

  ob_t           exp_q[$];
  ob_t           out_q[$];
  int            errs = 0;
  int            checks = 0;
  int            rem_pkts[NS], beats_left[NS], len_cfg[NS], seq[NS], gap[NS];
  bit            force_off[NS];
  int            tr_pct, gap_pct, cur_src;
  logic [NS-1:0] obs_rdy;
  logic [DW-1:0] sd[NS];

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    out_q.delete();
    cur_src = -1;
    gap_pct = 0;
    for (int i = 0; i < NS; i++) begin
      rem_pkts[i] = 0; beats_left[i] = 0; len_cfg[i] = 0;
      seq[i] = 0; gap[i] = 0; force_off[i] = 1'b0;
    end
  endtask

  function automatic bit model_idle();
    bit r;
    r = (exp_q.size() == 0);
    for (int i = 0; i < NS; i++) if (rem_pkts[i] != 0) r = 1'b0;
    return r;
  endfunction

  // One clock: drive sources, check outputs, then book the handshakes that
  // the coming edge will perform.
  task automatic step();
    logic [NS-1:0]    v, l;
    logic [NS*DW-1:0] dflat;
    logic             tr;
    @(posedge clk); #1;
    for (int i = 0; i < NS; i++) begin
      if (rem_pkts[i] > 0 && beats_left[i] == 0)
        beats_left[i] = (len_cfg[i] != 0) ? len_cfg[i] : int'($urandom_range(6, 1));
      if (gap[i] > 0) gap[i]--;
      else if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) gap[i] = int'($urandom_range(3, 1));
      v[i] = (rem_pkts[i] > 0) && !force_off[i] && (gap[i] == 0);
      l[i] = (beats_left[i] == 1);
      sd[i] = {8'(i), 24'(seq[i]), $urandom, $urandom, $urandom};
      dflat[i*DW +: DW] = sd[i];
    end
    tr = (int'($urandom_range(99)) < tr_pct);
    bus.src_valid = v;
    bus.src_last = l;
    bus.src_data = dflat;
    bus.M_AXIS_tready = tr;
    #1;
    obs_rdy = bus.src_ready;
    chk("rdy_onehot", 136'($onehot0(obs_rdy)), 136'(1));
    chk("fifo_count", 136'(bus.fifo_count), 136'(exp_q.size()));
    chk("tvalid", 136'(bus.M_AXIS_tvalid), 136'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      chk("head", 136'({bus.M_AXIS_tid, bus.M_AXIS_tlast, bus.M_AXIS_tdata}), 136'(exp_q[0]));
    if (exp_q.size() == FD) chk("full_blocks", 136'(obs_rdy), 136'(0));
    if (bus.M_AXIS_tvalid && tr) begin
      out_q.push_back({bus.M_AXIS_tid, bus.M_AXIS_tlast, bus.M_AXIS_tdata});
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    for (int i = 0; i < NS; i++) begin
      if (v[i] && obs_rdy[i]) begin
        if (cur_src >= 0) chk("no_interleave", 136'(i), 136'(cur_src));
        cur_src = l[i] ? -1 : i;
        exp_q.push_back({3'(i), l[i], sd[i]});
        seq[i]++;
        beats_left[i]--;
        if (beats_left[i] == 0) rem_pkts[i]--;
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    bit done;
    done = model_idle();
    while (!done && n < max_cyc) begin
      step();
      n++;
      done = model_idle();
    end
    chk("drain_done", 136'(done), 136'(1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.src_valid = '0;
    bus.src_last = '0;
    bus.src_data = '0;
    bus.M_AXIS_tready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 136'(bus.M_AXIS_tvalid), 136'(0));
    chk("rst_count", 136'(bus.fifo_count), 136'(0));
    chk("rst_ready", 136'(bus.src_ready), 136'(0));
    chk("rst_tdata", 136'(bus.M_AXIS_tdata), 136'(0));
    chk("rst_tid", 136'(bus.M_AXIS_tid), 136'(0));
    chk("rst_tlast", 136'(bus.M_AXIS_tlast), 136'(0));
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    int exp_t2[6];
    int exp_t6[6];
    exp_t2 = '{1, 1, 2, 2, 1, 1};
    exp_t6 = '{2, 2, 2, 2, 0, 0};
    tr_pct = 100;

    // Single 3-beat packet from source 0.
    do_reset();
    len_cfg[0] = 3; rem_pkts[0] = 1;
    step(); chk("t1_idle_rdy", 136'(obs_rdy), 136'(0));
    step(); chk("t1_grant_rdy", 136'(obs_rdy), 136'(4'b0001));
    drain(100);
    step(); chk("t1_back_idle", 136'(obs_rdy), 136'(0));
    chk("t1_beats", 136'(out_q.size()), 136'(3));
    for (int j = 0; j < out_q.size() && j < 3; j++) begin
      chk("t1_tid", 136'(out_q[j].tid), 136'(0));
      chk("t1_tlast", 136'(out_q[j].last), 136'(j == 2));
    end

    // Sources 1 and 2 contend; source 1 comes back and loses to 2.
    do_reset();
    len_cfg[1] = 2; rem_pkts[1] = 2;
    len_cfg[2] = 2; rem_pkts[2] = 1;
    drain(200);
    chk("t2_beats", 136'(out_q.size()), 136'(6));
    for (int j = 0; j < out_q.size() && j < 6; j++)
      chk("t2_rr_tid", 136'(out_q[j].tid), 136'(exp_t2[j]));

    // Backpressure: 20 beats into a 16-deep buffer, then release.
    do_reset();
    tr_pct = 0;
    len_cfg[0] = 20; rem_pkts[0] = 1;
    repeat (30) step();
    chk("t3_full_count", 136'(bus.fifo_count), 136'(16));
    chk("t3_full_rdy", 136'(obs_rdy), 136'(0));
    tr_pct = 100;
    drain(200);
    chk("t3_beats", 136'(out_q.size()), 136'(20));
    for (int j = 0; j < out_q.size() && j < 20; j++) begin
      chk("t3_order", 136'(out_q[j].data[119:96]), 136'(j));
      chk("t3_tlast", 136'(out_q[j].last), 136'(j == 19));
    end

    // Source 3 granted then withdraws; pending source 0 is served next.
    do_reset();
    rem_pkts[3] = 1; len_cfg[3] = 2;
    step(); chk("t4_arb_rdy", 136'(obs_rdy), 136'(0));
    force_off[3] = 1'b1; rem_pkts[0] = 1; len_cfg[0] = 2;
    step(); chk("t4_grant3", 136'(obs_rdy), 136'(4'b1000));
    step(); chk("t4_released", 136'(obs_rdy), 136'(0));
    chk("t4_no_write", 136'(bus.fifo_count), 136'(0));
    step(); chk("t4_grant0", 136'(obs_rdy), 136'(4'b0001));
    rem_pkts[3] = 0; beats_left[3] = 0; force_off[3] = 1'b0;
    drain(100);
    chk("t4_beats", 136'(out_q.size()), 136'(2));
    for (int j = 0; j < out_q.size() && j < 2; j++)
      chk("t4_tid", 136'(out_q[j].tid), 136'(0));

    // Asynchronous reset with two beats of a 4-beat packet buffered.
    do_reset();
    tr_pct = 0;
    len_cfg[0] = 4; rem_pkts[0] = 1;
    n = 0;
    while (exp_q.size() < 2 && n < 20) begin step(); n++; end
    force_off[0] = 1'b1;
    step();
    chk("t5_buffered", 136'(bus.fifo_count), 136'(2));
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_tvalid", 136'(bus.M_AXIS_tvalid), 136'(0));
    chk("t5_async_count", 136'(bus.fifo_count), 136'(0));
    do_reset();
    tr_pct = 100;
    len_cfg[1] = 2; rem_pkts[1] = 1;
    drain(100);
    chk("t5_beats", 136'(out_q.size()), 136'(2));
    for (int j = 0; j < out_q.size() && j < 2; j++) begin
      chk("t5_tid", 136'(out_q[j].tid), 136'(1));
      chk("t5_seq", 136'(out_q[j].data[119:96]), 136'(j));
    end

    // Grant on source 2 stays locked across a 5-cycle valid gap.
    do_reset();
    len_cfg[2] = 4; rem_pkts[2] = 1;
    step();
    len_cfg[0] = 2; rem_pkts[0] = 1;
    n = 0;
    while (seq[2] < 2 && n < 50) begin step(); n++; end
    force_off[2] = 1'b1;
    repeat (5) begin
      step();
      chk("t6_locked", 136'(obs_rdy), 136'(4'b0100));
    end
    force_off[2] = 1'b0;
    drain(100);
    chk("t6_beats", 136'(out_q.size()), 136'(6));
    for (int j = 0; j < out_q.size() && j < 6; j++)
      chk("t6_tid", 136'(out_q[j].tid), 136'(exp_t6[j]));

    // Random traffic: gaps, random lengths, random backpressure.
    do_reset();
    tr_pct = 70; gap_pct = 25;
    for (int i = 0; i < NS; i++) rem_pkts[i] = 8;
    drain(4000);
    do_reset();
    tr_pct = 25; gap_pct = 10;
    for (int i = 0; i < NS; i++) rem_pkts[i] = 6;
    drain(4000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 128, width of every source data bus and of the output stream.
REQ-002 SHALL have parameter NUM_SOURCES, 4, number of upstream submodule ports (R, W, AR, AW streamers); range 2..8.
REQ-003 SHALL have parameter FIFO_DEPTH, 16, output buffer depth in beats; power of two, at least 2.
REQ-004 SHALL have port clk  in  1  single clock; every register samples on the rising edge.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-006 SHALL have port src_valid  in  NUM_SOURCES  per-source "beat available".
REQ-007 SHALL have port src_last  in  NUM_SOURCES  per-source "this beat ends the packet".
REQ-008 SHALL have port src_data  in  NUM_SOURCES*DATA_WIDTH  packed source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port src_ready  out  NUM_SOURCES  per-source ready; at most one bit high in any cycle.
REQ-010 SHALL have port M_AXIS_tdata  out  DATA_WIDTH  output stream data.
REQ-011 SHALL have port M_AXIS_tid  out  3  index of the source that produced the beat.
REQ-012 SHALL have port M_AXIS_tlast  out  1  end of packet.
REQ-013 SHALL have port M_AXIS_tvalid  out  1  output beat valid.
REQ-014 SHALL have port M_AXIS_tready  in  1  downstream ready.
REQ-015 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-016 SHALL implement a state machine with states IDLE, GRANT and PACKET, plus a registered grant index gnt.
REQ-017 In IDLE with any src_valid bit high, SHALL load gnt with the first requesting index strictly after the previous gnt, wrapping modulo NUM_SOURCES (round-robin), then enter GRANT on the next edge; arbitration latency is 1 cycle.
REQ-018 SHALL drive src_ready[gnt] = (state is GRANT or PACKET) and FIFO not full, and all other src_ready bits 0; src_ready SHALL be 0 in IDLE.
REQ-019 Source data SHALL be sampled only in a cycle with src_valid[gnt] and src_ready[gnt] both high, because sources present data only during that handshake.
REQ-020 Each accepted beat SHALL be written into the FIFO as {gnt, src_last[gnt], src_data[gnt]}.
REQ-021 GRANT to PACKET on the first accepted beat whose last is 0; GRANT or PACKET to IDLE on an accepted beat whose last is 1.
REQ-022 In GRANT with src_valid[gnt] low, SHALL return to IDLE without writing (release of a grant with no beats accepted); in PACKET the grant SHALL stay locked regardless of src_valid until last is accepted.
REQ-023 The FIFO SHALL be first-word fall-through: M_AXIS_tvalid = (fifo_count != 0), and the outputs show the head entry.
REQ-024 A pop SHALL occur on M_AXIS_tvalid and M_AXIS_tready; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-025 Full (fifo_count == FIFO_DEPTH) SHALL block the push via src_ready; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 When the FIFO is full and a pop occurs in the same cycle, src_ready SHALL still be 0 that cycle; there is no combinational path from tready to src_ready.
REQ-027 Output ordering SHALL preserve acceptance order; beats from different sources SHALL never interleave within a packet.
REQ-028 M_AXIS_tid bits above $clog2(NUM_SOURCES) SHALL be 0.

Reset
REQ-029 While resetn is low: state IDLE, gnt = NUM_SOURCES-1 (so source 0 wins first), FIFO pointers 0, fifo_count 0, M_AXIS_tvalid 0, src_ready all 0, M_AXIS_tdata/tid/tlast 0.
REQ-030 Reset asserted mid-packet SHALL discard buffered beats and the partial packet; after release the block SHALL start in IDLE with no residual grant lock.

Verification
REQ-031 Single source 0 sends a 3-beat packet (meta 0x6..., data 0xA5, last 0x3...) with tready=1 -> src_ready[0] high starting 1 cycle after valid, output tid=0, tlast only on beat 3, back to IDLE.
REQ-032 Sources 1 and 2 valid at the same time from reset -> source 1 packet fully output, then source 2; next contest between 1 and 2 -> 2 wins (round-robin).
REQ-033 tready=0 while source 0 streams 20 beats with FIFO_DEPTH=16 -> fifo_count stops at 16 and src_ready drops; tready=1 -> all 20 beats exit in order, none lost or duplicated.
REQ-034 Source 3 is granted, then drops valid before any beat -> IDLE after 1 cycle, no FIFO write, a pending source 0 is granted next.
REQ-035 resetn pulsed low after beat 2 of a 4-beat packet with 2 beats buffered -> tvalid 0 and fifo_count 0 immediately (asynchronous); the next packet is output cleanly.
REQ-036 Mid-packet src_valid gap of 5 cycles on granted source 2 while source 0 requests -> grant stays on 2 until its last beat, with no source-0 beats interleaved.
